// File: rtl/apb_pkg.sv
// Shared APB master definitions: bus widths, FSM state encoding and the
// default ACCESS-phase abort limit.
package apb_pkg;
  localparam int APB_ADDR_W      = 32;
  localparam int APB_DATA_W      = 32;
  localparam int APB_STRB_W      = 4;
  localparam int APB_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;
endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter: the requester not granted last wins a tie.
// After reset the last-grant register points at requester 1, so requester 0 goes first.
module apb_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);
  logic last_q;

  always_comb begin
    gnt_id = 1'b0;
    if (req == 2'b11) gnt_id = ~last_q;
    else if (req[1])  gnt_id = 1'b1;
    gnt = (|req) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst)          last_q <= 1'b1;
    else if (advance) last_q <= gnt_id;
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin grant, SETUP/ACCESS
// sequencing, wait-state timeout and per-requester response pulses.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [APB_ADDR_W-1:0] req0_addr,
  input  logic [APB_DATA_W-1:0] req0_wdata,
  input  logic [APB_STRB_W-1:0] req0_strb,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [APB_ADDR_W-1:0] req1_addr,
  input  logic [APB_DATA_W-1:0] req1_wdata,
  input  logic [APB_STRB_W-1:0] req1_strb,
  output logic                  rsp0_valid,
  output logic [APB_DATA_W-1:0] rsp0_rdata,
  output logic                  rsp0_error,
  output logic                  rsp1_valid,
  output logic [APB_DATA_W-1:0] rsp1_rdata,
  output logic                  rsp1_error,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_STRB_W-1:0] PSTRB,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PERROR,
  output logic [1:0]            dbg_state
);
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  apb_state_e state_q, state_d;
  logic [1:0] gnt;
  logic       gnt_id, gnt_id_q;
  logic       accept, done, timeout_hit;
  logic       sel_write;
  logic [APB_ADDR_W-1:0] sel_addr, paddr_q;
  logic [APB_DATA_W-1:0] sel_wdata, pwdata_q, rsp_rdata_q;
  logic [APB_STRB_W-1:0] sel_strb, pstrb_q;
  logic       pwrite_q;
  logic [7:0] wait_q;
  logic       rsp_valid_q, rsp_id_q, rsp_error_q;

  apb_rr_arbiter u_arb (
    .clk     (PCLK),
    .rst     (PRESET),
    .req     ({req1_valid, req0_valid}),
    .advance (accept),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // Ready is gated by reset so nothing is handed over in a cycle whose edge discards it.
  assign accept      = (state_q == IDLE) && (|gnt) && !PRESET;
  assign req0_ready  = accept && gnt[0];
  assign req1_ready  = accept && gnt[1];
  assign timeout_hit = !PREADY && (wait_q == WAIT_LIMIT);
  assign done        = (state_q == ACCESS) && (PREADY || timeout_hit);

  assign sel_write = gnt_id ? req1_write : req0_write;
  assign sel_addr  = gnt_id ? req1_addr  : req0_addr;
  assign sel_wdata = gnt_id ? req1_wdata : req0_wdata;
  assign sel_strb  = gnt_id ? req1_strb  : req0_strb;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      gnt_id_q    <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_id_q <= gnt_id;
        pwrite_q <= sel_write;
        paddr_q  <= sel_addr;
        pwdata_q <= sel_write ? sel_wdata : '0;
        pstrb_q  <= sel_write ? sel_strb  : '0;
      end
      if (state_q == ACCESS && !PREADY) wait_q <= wait_q + 8'd1;
      else                              wait_q <= '0;
      rsp_valid_q <= done;
      if (done) begin
        rsp_id_q    <= gnt_id_q;
        rsp_rdata_q <= (PREADY && !pwrite_q) ? PRDATA : '0;
        rsp_error_q <= PREADY ? PERROR : 1'b1;
      end
    end
  end

  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign dbg_state = state_q;

  assign rsp0_valid = rsp_valid_q && !rsp_id_q;
  assign rsp1_valid = rsp_valid_q &&  rsp_id_q;
  assign rsp0_rdata = rsp_rdata_q;
  assign rsp1_rdata = rsp_rdata_q;
  assign rsp0_error = rsp_error_q;
  assign rsp1_error = rsp_error_q;
endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum ACCESS-phase cycles before abort (range 2..255).
REQ-002 PCLK  in  1  clock; all logic rising-edge. One clock only.
REQ-003 PRESET  in  1  reset; synchronous, active-high.
REQ-004 reqN_valid  in  1  requester N (N=0,1) has a command pending; held until reqN_ready.
REQ-005 reqN_ready  out  1  one-cycle pulse; command of requester N accepted this cycle.
REQ-006 reqN_write  in  1  1=write, 0=read.
REQ-007 reqN_addr  in  32  target address.
REQ-008 reqN_wdata  in  32  write data.
REQ-009 reqN_strb  in  4  write byte strobes.
REQ-010 rspN_valid  out  1  one-cycle pulse; transfer for requester N finished.
REQ-011 rspN_rdata  out  32  read data; 0 for writes and aborts; valid only with rspN_valid.
REQ-012 rspN_error  out  1  PERROR captured, or timeout abort; valid only with rspN_valid.
REQ-013 PSEL, PENABLE, PWRITE  out  1 each  APB master control.
REQ-014 PADDR, PWDATA  out  32 each; PSTRB  out  4; PRDATA  in  32; PREADY, PERROR  in  1 each.

Function
REQ-015 FSM states IDLE, SETUP, ACCESS; IDLE: PSEL=0, PENABLE=0.
REQ-016 IDLE with any reqN_valid: grant one requester, pulse its reqN_ready, latch write/addr/wdata/strb and grant id, go SETUP next cycle.
REQ-017 Arbitration round-robin: sole requester wins; both valid -> requester not granted last wins; after reset req0 has priority.
REQ-018 SETUP: PSEL=1, PENABLE=0, lasts exactly one cycle, then ACCESS.
REQ-019 ACCESS: PSEL=1, PENABLE=1; transfer completes on first edge with PREADY=1.
REQ-020 On completion: PSEL/PENABLE drop next cycle, rsp of granted requester pulses that cycle with rdata=PRDATA (reads) or 0 (writes), error=PERROR; FSM to IDLE.
REQ-021 Latency: accept at cycle T -> PSEL T+1 -> PENABLE T+2 -> with zero wait states rsp_valid at T+3; next accept earliest T+3.
REQ-022 PADDR, PWRITE, PWDATA, PSTRB stable from SETUP through last ACCESS cycle; PSTRB=0 for reads; PWDATA=0 for reads.
REQ-023 Wait counter (8 bits) counts ACCESS cycles with PREADY=0; reaching TIMEOUT aborts: PSEL/PENABLE drop, rsp pulses with error=1, rdata=0.
REQ-024 PREADY/PERROR/PRDATA ignored outside ACCESS.
REQ-025 reqN_valid deasserting before acceptance is legal; no grant issued for it.
REQ-026 At most one rsp pulse per accepted request; rsp0_valid and rsp1_valid never both 1.

Reset
REQ-027 PRESET=1 on an edge: FSM=IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, PSTRB=0, all ready/rsp outputs 0, wait counter 0, priority to req0.
REQ-028 Reset mid-transfer aborts it silently: no rsp pulse issued; requester must re-issue.

Structure
REQ-029 Shared package apb_pkg holds state enum (IDLE/SETUP/ACCESS), APB_ADDR_W=32, APB_DATA_W=32, APB_STRB_W=4, default TIMEOUT.
REQ-030 One sub-module apb_rr_arbiter (2-way round-robin, grant + last-grant register); FSM and datapath in top.

Verification
REQ-031 req0 write addr 5, wdata A5A5A5A5, strb 1100, PREADY=1 -> PSEL T+1, PENABLE T+2, PSTRB=1100, rsp0_valid T+3, error=0.
REQ-032 req0 read addr 5, peripheral PRDATA=A5A50000 -> rsp0_rdata=A5A50000, PSTRB=0000, error=0.
REQ-033 req1 write addr 20, strb 1111, peripheral PERROR=1 -> rsp1_error=1, rsp1_rdata=0.
REQ-034 req0 and req1 valid same cycle after reset, three requests each -> grant order 0,1,0,1,0,1; each rsp to correct requester.
REQ-035 PREADY held 0, TIMEOUT=16 -> 16 ACCESS cycles, then PSEL=0, rsp error=1; 3 PREADY wait cycles instead -> rsp at T+6, error=0.
REQ-036 PRESET asserted during ACCESS -> next edge PSEL=PENABLE=0, no rsp pulse; subsequent request completes normally.
